// File: rtl/ncl_request_controller.sv
// Dual-rail request decoder for the datapath sequencer. Decodes PH0/PH1/Rd/Ld
// into compute (R_c) and memory (R_m) requests, following NULL/DATA wavefront
// discipline: latch on a complete DATA set, release on a complete NULL set.
module ncl_request_controller (
  input  logic clk,
  input  logic rst_n,
  input  logic PH0_t,
  input  logic PH0_f,
  input  logic PH1_t,
  input  logic PH1_f,
  input  logic Rd_t,
  input  logic Rd_f,
  input  logic Ld_t,
  input  logic Ld_f,
  output logic R_c_t,
  output logic R_c_f,
  output logic R_m_t,
  output logic R_m_f,
  output logic ko,
  output logic err
);

  typedef enum logic [0:0] {StWaitData, StWaitNull} state_e;

  state_e     state_q, state_d;
  logic       rc_q, rc_d;
  logic       rm_q, rm_d;
  logic       err_q, err_d;
  logic [1:0] rst_sync_q;
  logic       run;

  logic [3:0] t_rails, f_rails;
  logic       illegal, all_null, complete;
  logic       dec_rc, dec_rm;

  // Rails ordered {PH0, PH1, Rd, Ld}
  assign t_rails = {PH0_t, PH1_t, Rd_t, Ld_t};
  assign f_rails = {PH0_f, PH1_f, Rd_f, Ld_f};

  // Input set classification; a pair is DATA exactly when its rails differ,
  // so an ILLEGAL pair can never make the set complete.
  assign illegal  = |(t_rails & f_rails);
  assign all_null = ~|(t_rails | f_rails);
  assign complete = &(t_rails ^ f_rails);

  // Request decode on the true rails (only meaningful when complete)
  assign dec_rm = t_rails[3] | (t_rails[2] & t_rails[0]);
  assign dec_rc = ~t_rails[3] & t_rails[2] & t_rails[1];

  // Reset release synchronizer: assert async, deassert after two clk edges
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign run = rst_sync_q[1];

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StWaitData;
      rc_q    <= 1'b0;
      rm_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      rm_q    <= rm_d;
      err_q   <= err_d;
    end
  end

  // Next-state: latch decode on complete DATA, release on all NULL
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    rm_d    = rm_q;
    err_d   = 1'b0;
    if (run) begin
      err_d = illegal;
      unique case (state_q)
        StWaitData: begin
          if (complete) begin
            state_d = StWaitNull;
            rc_d    = dec_rc;
            rm_d    = dec_rm;
          end
        end
        StWaitNull: begin
          // New DATA or partial sets are ignored until a full NULL returns
          if (all_null) begin
            state_d = StWaitData;
            rc_d    = 1'b0;
            rm_d    = 1'b0;
          end
        end
        default: state_d = StWaitData;
      endcase
    end
  end

  // Outputs: "no request" is signalled by NULL, so false rails stay low
  always_comb begin
    R_c_t = rc_q;
    R_c_f = 1'b0;
    R_m_t = rm_q;
    R_m_f = 1'b0;
    ko    = (state_q == StWaitData);
    err   = err_q;
  end

endmodule

// File: tb/tb_ncl_request_controller.sv
// Self-checking bench for ncl_request_controller using an expected-value queue.
module tb_ncl_request_controller;

  logic clk = 1'b0;
  logic rst_n;
  logic PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f;
  logic R_c_t, R_c_f, R_m_t, R_m_f, ko, err;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string tag;
    bit    rc;
    bit    rm;
    bit    ko;
  } exp_t;

  exp_t sb_q[$];

  ncl_request_controller dut (
    .clk   (clk),
    .rst_n (rst_n),
    .PH0_t (PH0_t),
    .PH0_f (PH0_f),
    .PH1_t (PH1_t),
    .PH1_f (PH1_f),
    .Rd_t  (Rd_t),
    .Rd_f  (Rd_f),
    .Ld_t  (Ld_t),
    .Ld_f  (Ld_f),
    .R_c_t (R_c_t),
    .R_c_f (R_c_f),
    .R_m_t (R_m_t),
    .R_m_f (R_m_f),
    .ko    (ko),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {PH0_t,PH0_f,PH1_t,PH1_f,Rd_t,Rd_f,Ld_t,Ld_f}
  task automatic set_rails(input logic [7:0] r);
    {PH0_t, PH0_f, PH1_t, PH1_f, Rd_t, Rd_f, Ld_t, Ld_f} = r;
  endtask

  function automatic logic [7:0] data_rails(input int idx);
    logic [3:0] b;
    b = idx[3:0];
    return {b[3], ~b[3], b[2], ~b[2], b[1], ~b[1], b[0], ~b[0]};
  endfunction

  // Expected decode straight from the truth table
  function automatic exp_t table_exp(input int idx, input string tag);
    exp_t e;
    e.tag = tag;
    e.ko  = 1'b0;
    e.rc  = (idx == 6) || (idx == 7);
    e.rm  = (idx == 5) || (idx == 7) || (idx >= 8);
    return e;
  endfunction

  function automatic exp_t mk_exp(input string tag, input bit rc, input bit rm, input bit k);
    exp_t e;
    e.tag = tag;
    e.rc  = rc;
    e.rm  = rm;
    e.ko  = k;
    return e;
  endfunction

  task automatic compare_outputs();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_val("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    check_val({e.tag, ".R_c_t"}, 32'(R_c_t), 32'(e.rc));
    check_val({e.tag, ".R_m_t"}, 32'(R_m_t), 32'(e.rm));
    check_val({e.tag, ".R_c_f"}, 32'(R_c_f), 32'd0);
    check_val({e.tag, ".R_m_f"}, 32'(R_m_f), 32'd0);
    check_val({e.tag, ".ko"},    32'(ko),    32'(e.ko));
    check_val({e.tag, ".err"},   32'(err),   32'd0);
  endtask

  // Drive a wavefront, queue its expectation, wait n edges, then compare
  task automatic apply(input logic [7:0] r, input exp_t e, input int n);
    set_rails(r);
    sb_q.push_back(e);
    repeat (n) @(posedge clk);
    #1;
    compare_outputs();
  endtask

  initial begin
    // Reset with arbitrary DATA on the inputs: outputs must be NULL at once
    rst_n = 1'b0;
    set_rails(data_rails(7));
    #2;
    sb_q.push_back(mk_exp("reset", 1'b0, 1'b0, 1'b1));
    compare_outputs();
    set_rails(8'h00);
    #10;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Full truth-table sweep
    for (int i = 0; i < 16; i++) begin
      apply(8'h00, mk_exp($sformatf("null%0d", i), 1'b0, 1'b0, 1'b1), 2);
      apply(data_rails(i), table_exp(i, $sformatf("idx%0d", i)), 2);
    end

    // Hysteresis: index 7 latched, Ld goes NULL, then everything NULL
    apply(8'h00, mk_exp("hyst_null0", 1'b0, 1'b0, 1'b1), 2);
    apply(data_rails(7), table_exp(7, "hyst_idx7"), 2);
    apply(data_rails(7) & 8'hFC, mk_exp("hyst_partial", 1'b1, 1'b1, 1'b0), 2);
    apply(data_rails(2), mk_exp("hyst_newdata", 1'b1, 1'b1, 1'b0), 2);
    apply(8'h00, mk_exp("hyst_release", 1'b0, 1'b0, 1'b1), 1);

    // Partial DATA: only PH0/PH1 present, then completed to index 5
    apply(8'h00, mk_exp("part_null", 1'b0, 1'b0, 1'b1), 2);
    apply(data_rails(5) & 8'hF0, mk_exp("part_ph", 1'b0, 1'b0, 1'b1), 2);
    apply(data_rails(5), table_exp(5, "part_idx5"), 2);

    // Illegal PH1 pair in WAIT_DATA: one-cycle err pulse, nothing else moves
    apply(8'h00, mk_exp("ill_null", 1'b0, 1'b0, 1'b1), 2);
    set_rails(8'b0011_0000);
    @(posedge clk);
    #1;
    check_val("ill_err_hi", 32'(err), 32'd1);
    check_val("ill_ko", 32'(ko), 32'd1);
    check_val("ill_rails", 32'({R_c_t, R_m_t}), 32'd0);
    set_rails(8'h00);
    @(posedge clk);
    #1;
    check_val("ill_err_lo", 32'(err), 32'd0);
    check_val("ill_ko_after", 32'(ko), 32'd1);
    // Illegal set must not have been latched as DATA
    apply(8'h00, mk_exp("ill_hold", 1'b0, 1'b0, 1'b1), 2);

    // Reset mid-operation with index 15 latched
    apply(data_rails(15), table_exp(15, "rst_idx15"), 2);
    #2;
    rst_n = 1'b0;
    #1;
    sb_q.push_back(mk_exp("rst_async", 1'b0, 1'b0, 1'b1));
    compare_outputs();
    set_rails(8'h00);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    apply(data_rails(6), table_exp(6, "post_rst_idx6"), 2);
    apply(8'h00, mk_exp("post_rst_null", 1'b0, 1'b0, 1'b1), 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Safety net against a stalled run
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/ncl_request_controller.md
Name: ncl_request_controller

Overview:
- Dual-rail (NCL-style) request decoder for the datapath sequencer.
- Takes four dual-rail control inputs (phase PH0, phase PH1, read Rd, load Ld) and issues two dual-rail request outputs: R_c (compute request) and R_m (memory request).
- Operates in a clocked wrapper with NULL/DATA wavefront discipline: decodes only on a complete DATA set, and returns to NULL only on a complete NULL set.

Parameters:
- none

Ports:
- clk      input   1  system clock, rising-edge active
- rst_n    input   1  asynchronous active-low reset
- PH0_t    input   1  phase 0, true rail
- PH0_f    input   1  phase 0, false rail
- PH1_t    input   1  phase 1, true rail
- PH1_f    input   1  phase 1, false rail
- Rd_t     input   1  read, true rail
- Rd_f     input   1  read, false rail
- Ld_t     input   1  load, true rail
- Ld_f     input   1  load, false rail
- R_c_t    output  1  compute request, true rail
- R_c_f    output  1  compute request, false rail (never asserted)
- R_m_t    output  1  memory request, true rail
- R_m_f    output  1  memory request, false rail (never asserted)
- ko       output  1  completion/acknowledge: 1 = ready for DATA, 0 = ready for NULL
- err      output  1  one-cycle pulse on an illegal rail pair

Behaviour:
- Rail encoding per signal:
  - (t,f) = (0,0) is NULL.
  - (0,1) is DATA0.
  - (1,0) is DATA1.
  - (1,1) is ILLEGAL.
- Input set classification (combinational):
  - COMPLETE_DATA: all four inputs are DATA0 or DATA1.
  - ALL_NULL: all eight rails are 0.
  - PARTIAL: anything else that contains no ILLEGAL pair.
- Decode, applied only on COMPLETE_DATA:
  - R_m = DATA1 when PH0 | (PH1 & Ld); otherwise NULL.
  - R_c = DATA1 when ~PH0 & PH1 & Rd; otherwise NULL.
  - False rails R_c_f and R_m_f are tied low; "no request" is signalled by NULL.
- Decode truth table, index = {PH0,PH1,Rd,Ld} with PH0 as MSB:
  - 0–4: R_c NULL, R_m NULL.
  - 5: R_c NULL, R_m 1.
  - 6: R_c 1, R_m NULL.
  - 7: R_c 1, R_m 1.
  - 8–15: R_c NULL, R_m 1.
- State machine (registered, 2 states):
  - WAIT_DATA: outputs NULL, ko=1.
    - On COMPLETE_DATA: register the decoded outputs, go to WAIT_NULL.
    - On PARTIAL or ALL_NULL: stay.
  - WAIT_NULL: outputs hold the decoded value, ko=0.
    - On ALL_NULL: outputs go NULL, go to WAIT_DATA.
    - On PARTIAL or a new DATA set: hold (hysteresis; a new DATA set is not re-decoded).
- Latency: outputs and ko update on the clk edge after the qualifying input set; one cycle.
- ILLEGAL pair on any input:
  - err=1 for one cycle, on the next edge.
  - State and outputs unchanged.
  - In WAIT_DATA an ILLEGAL set never counts as COMPLETE_DATA.
- Reset (rst_n=0, asynchronous):
  - State = WAIT_DATA, all R_* rails = 0, ko=1, err=0.
  - Asserting reset mid-DATA forces NULL outputs immediately.
  - Deassertion is synchronized internally to clk (2-flop) before the FSM leaves reset.
- Inputs are sampled directly on clk; the upstream stage holds each wavefront stable for at least 2 cycles.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> all R_* rails 0, ko=1, err=0 immediately, without waiting for a clk edge.
- Full truth-table sweep: for each index 0–15, drive a NULL wavefront for 2 cycles and then the DATA wavefront for 2 cycles.
  - Index 5 -> R_m_t=1, R_c_t=0.
  - Index 6 -> R_c_t=1, R_m_t=0.
  - Index 7 -> R_c_t=1, R_m_t=1.
  - Indices 8–15 -> R_m_t=1, R_c_t=0.
  - Indices 0–4 -> all rails 0.
  - Check R_c_f = R_m_f = 0 and ko=0 after each DATA wavefront; ko=1 after each NULL wavefront.
- Hysteresis: after index 7 is latched, change Ld to NULL only (partial set) -> outputs remain R_c_t=1, R_m_t=1, ko=0. Then all inputs NULL -> outputs all 0 and ko=1 one cycle later.
- Partial DATA: from NULL, assert only PH0 and PH1 -> outputs stay NULL, ko=1. Complete with Rd=0, Ld=1 (index 5) -> R_m_t=1.
- Illegal: set PH1_t = PH1_f = 1 in WAIT_DATA -> err pulses for exactly 1 cycle, no state change, outputs NULL.
- Reset mid-operation: with index 15 latched (R_m_t=1), pulse rst_n low -> R_m_t=0 asynchronously. After release, the next complete DATA set is decoded normally.
